// File: rtl/seg_scan.sv
// rtl/seg_scan.sv - six-digit 7-segment scanner with per-frame latch and blanking gap
//
// Purpose: time-multiplexes six 7-segment patterns (digit 1 = rightmost) onto a
// shared segment bus with six digit enables. Each digit slot starts with a
// blanking gap to suppress ghosting. All six patterns are latched once per frame.
//
// Ports:
//   mclk        system clock
//   rst         asynchronous, active-high reset
//   en          scan enable; 0 holds the scan at slot 0 with outputs off
//   seg_in1..6  segment patterns, bit=1 lit; seg_in1 is the rightmost digit
//   dp_mask     decimal points, bit k lights the DP of digit k+1
//   seg_out     shared segment bus (registered)
//   dp_out      shared decimal-point line (registered)
//   dig_out     digit enables, bit k drives digit k+1 (registered)
//   frame_tick  one-cycle pulse on the cycle after the frame capture

module seg_scan #(
  parameter int SCAN_DIV   = 1000,
  parameter int BLANK_CYC  = 50,
  parameter int ACTIVE_LOW = 1
) (
  input  logic       mclk,
  input  logic       rst,
  input  logic       en,
  input  logic [6:0] seg_in1,
  input  logic [6:0] seg_in2,
  input  logic [6:0] seg_in3,
  input  logic [6:0] seg_in4,
  input  logic [6:0] seg_in5,
  input  logic [6:0] seg_in6,
  input  logic [5:0] dp_mask,
  output logic [6:0] seg_out,
  output logic       dp_out,
  output logic [5:0] dig_out,
  output logic       frame_tick
);

  localparam int CW_DIV = $clog2(SCAN_DIV);
  localparam int CW_BLK = $clog2(BLANK_CYC + 1);
  localparam int CW     = (CW_DIV > CW_BLK) ? CW_DIV : CW_BLK;

  localparam logic [CW-1:0] CYC_LAST = CW'(SCAN_DIV - 1);
  localparam logic [CW-1:0] BLANK_V  = CW'(BLANK_CYC);
  localparam logic          INV      = (ACTIVE_LOW != 0);

  logic [CW-1:0] cyc;
  logic [2:0]    slot;
  logic [6:0]    sh1, sh2, sh3, sh4, sh5, sh6;
  logic [5:0]    sh_dp;

  logic [6:0]    nsh1, nsh2, nsh3, nsh4, nsh5, nsh6;
  logic [5:0]    nsh_dp;
  logic          capture;
  logic          blank;
  logic          lit;
  logic [6:0]    pat;
  logic          dpb;
  logic [5:0]    onehot;
  logic [6:0]    seg_n;
  logic          dp_n;
  logic [5:0]    dig_n;

  assign capture = en && (slot == 3'd0) && (cyc == '0);

  always_comb begin
    // Shadow contents as they will be after this edge; lets slot 0 show the
    // freshly captured pattern even when there is no blank phase.
    nsh1   = sh1;
    nsh2   = sh2;
    nsh3   = sh3;
    nsh4   = sh4;
    nsh5   = sh5;
    nsh6   = sh6;
    nsh_dp = sh_dp;
    if (capture) begin
      nsh1   = seg_in1;
      nsh2   = seg_in2;
      nsh3   = seg_in3;
      nsh4   = seg_in4;
      nsh5   = seg_in5;
      nsh6   = seg_in6;
      nsh_dp = dp_mask;
    end

    pat    = '0;
    dpb    = 1'b0;
    onehot = '0;
    case (slot)
      3'd0:    begin pat = nsh1; dpb = nsh_dp[0]; onehot = 6'b000001; end
      3'd1:    begin pat = nsh2; dpb = nsh_dp[1]; onehot = 6'b000010; end
      3'd2:    begin pat = nsh3; dpb = nsh_dp[2]; onehot = 6'b000100; end
      3'd3:    begin pat = nsh4; dpb = nsh_dp[3]; onehot = 6'b001000; end
      3'd4:    begin pat = nsh5; dpb = nsh_dp[4]; onehot = 6'b010000; end
      3'd5:    begin pat = nsh6; dpb = nsh_dp[5]; onehot = 6'b100000; end
      default: begin pat = '0;   dpb = 1'b0;      onehot = 6'b000000; end
    endcase

    blank = (BLANK_CYC > 0) && (cyc < BLANK_V);
    lit   = en && !blank;

    seg_n = (lit ? pat    : 7'h00) ^ {7{INV}};
    dp_n  = (lit ? dpb    : 1'b0)  ^ INV;
    dig_n = (lit ? onehot : 6'h00) ^ {6{INV}};
  end

  always_ff @(posedge mclk or posedge rst) begin
    if (rst) begin
      cyc  <= '0;
      slot <= 3'd0;
    end else if (!en) begin
      cyc  <= '0;
      slot <= 3'd0;
    end else if (cyc == CYC_LAST) begin
      cyc  <= '0;
      slot <= (slot == 3'd5) ? 3'd0 : 3'(slot + 3'd1);
    end else begin
      cyc  <= cyc + CW'(1);
    end
  end

  always_ff @(posedge mclk or posedge rst) begin
    if (rst) begin
      sh1   <= '0;
      sh2   <= '0;
      sh3   <= '0;
      sh4   <= '0;
      sh5   <= '0;
      sh6   <= '0;
      sh_dp <= '0;
    end else begin
      sh1   <= nsh1;
      sh2   <= nsh2;
      sh3   <= nsh3;
      sh4   <= nsh4;
      sh5   <= nsh5;
      sh6   <= nsh6;
      sh_dp <= nsh_dp;
    end
  end

  always_ff @(posedge mclk or posedge rst) begin
    if (rst) begin
      seg_out    <= {7{INV}};
      dp_out     <= INV;
      dig_out    <= {6{INV}};
      frame_tick <= 1'b0;
    end else begin
      seg_out    <= seg_n;
      dp_out     <= dp_n;
      dig_out    <= dig_n;
      frame_tick <= capture;
    end
  end

endmodule

// File: tb/tb_seg_scan.sv
// tb/tb_seg_scan.sv - self-checking bench for seg_scan (SCAN_DIV=8, BLANK_CYC=2, active-low)

module tb_seg_scan;

  localparam int SD = 8;
  localparam int BC = 2;
  localparam int FRAME = 6 * SD;

  logic       mclk = 1'b0;
  logic       rst  = 1'b0;
  logic       en   = 1'b1;
  logic [6:0] seg_in1 = 7'h3F;
  logic [6:0] seg_in2 = 7'h06;
  logic [6:0] seg_in3 = 7'h5B;
  logic [6:0] seg_in4 = 7'h66;
  logic [6:0] seg_in5 = 7'h6D;
  logic [6:0] seg_in6 = 7'h7D;
  logic [5:0] dp_mask = 6'b000100;
  logic [6:0] seg_out;
  logic       dp_out;
  logic [5:0] dig_out;
  logic       frame_tick;

  seg_scan #(.SCAN_DIV(SD), .BLANK_CYC(BC), .ACTIVE_LOW(1)) dut (
    .mclk(mclk), .rst(rst), .en(en),
    .seg_in1(seg_in1), .seg_in2(seg_in2), .seg_in3(seg_in3),
    .seg_in4(seg_in4), .seg_in5(seg_in5), .seg_in6(seg_in6),
    .dp_mask(dp_mask),
    .seg_out(seg_out), .dp_out(dp_out), .dig_out(dig_out), .frame_tick(frame_tick)
  );

  always #5 mclk = ~mclk;

  int n_chk  = 0;
  int n_pass = 0;
  bit chk_on = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, want %h at %0t", name, act, exp, $time);
  endtask

  // Model: a frame is 48 enabled cycles; position p in the frame gives slot
  // p/8 and in-slot cycle p%8. The frame picture is latched when p==0.
  int         pos;
  logic [6:0] m_seg [6];
  logic [5:0] m_dp;
  logic [6:0] e_seg;
  logic       e_dp;
  logic [5:0] e_dig;
  logic       e_tick;

  always @(posedge mclk or posedge rst) begin
    if (rst || !en) begin
      pos = 0;
      e_seg = 7'h7F; e_dp = 1'b1; e_dig = 6'h3F; e_tick = 1'b0;
    end else begin
      int s, c;
      if (pos == 0) begin
        m_seg[0] = seg_in1; m_seg[1] = seg_in2; m_seg[2] = seg_in3;
        m_seg[3] = seg_in4; m_seg[4] = seg_in5; m_seg[5] = seg_in6;
        m_dp = dp_mask;
      end
      e_tick = (pos == 0);
      s = pos / SD;
      c = pos % SD;
      if (c < BC) begin
        e_seg = 7'h7F; e_dp = 1'b1; e_dig = 6'h3F;
      end else begin
        e_dig = 6'h3F & ~(6'd1 << s);
        e_seg = ~m_seg[s];
        e_dp  = ~m_dp[s];
      end
      pos = (pos + 1) % FRAME;
    end
  end

  always @(negedge mclk) begin
    if (chk_on) begin
      chk("seg_out", 32'(seg_out), 32'(e_seg));
      chk("dp_out", 32'(dp_out), 32'(e_dp));
      chk("dig_out", 32'(dig_out), 32'(e_dig));
      chk("frame_tick", 32'(frame_tick), 32'(e_tick));
      chk("dig_exclusive", 32'($countones(~dig_out) <= 1), 32'd1);
      if (dig_out == 6'h3F) chk("blank_quiet", 32'({dp_out, seg_out}), 32'h0FF);
    end
  end

  task automatic wait_tick(input string name);
    bit seen = 1'b0;
    for (int k = 0; k < 4 * FRAME; k++) begin
      @(negedge mclk);
      if (frame_tick) begin seen = 1'b1; break; end
    end
    chk(name, 32'(seen), 32'd1);
  endtask

  initial begin
    #2 rst = 1'b1;
    #1;
    chk("rst_seg", 32'(seg_out), 32'h7F);
    chk("rst_dp", 32'(dp_out), 32'h1);
    chk("rst_dig", 32'(dig_out), 32'h3F);
    chk("rst_tick", 32'(frame_tick), 32'h0);
    chk_on = 1'b1;
    @(negedge mclk);
    rst = 1'b0;

    // Frame 1: i counts negedges from the tick cycle (slot 0, in-slot cycle 0).
    wait_tick("first_tick");
    for (int i = 1; i < FRAME; i++) begin
      @(negedge mclk);
      if (i == 1)  chk("f1_blank1", 32'(dig_out), 32'h3F);
      if (i == 2)  begin chk("f1_d1_dig", 32'(dig_out), 32'h3E); chk("f1_d1_seg", 32'(seg_out), 32'h40); end
      if (i == 9)  chk("f1_blank_s1", 32'(dig_out), 32'h3F);
      if (i == 10) begin
        chk("f1_d2_dig", 32'(dig_out), 32'h3D); chk("f1_d2_seg", 32'(seg_out), 32'h79);
        chk("f1_d2_dp", 32'(dp_out), 32'h1);
        seg_in3 = 7'h4F;
      end
      if (i == 18) begin
        chk("f1_d3_dig", 32'(dig_out), 32'h3B); chk("f1_d3_old", 32'(seg_out), 32'h24);
        chk("f1_d3_dp", 32'(dp_out), 32'h0);
      end
      if (i == 47) begin chk("f1_d6_dig", 32'(dig_out), 32'h1F); chk("f1_d6_seg", 32'(seg_out), 32'h02); end
      if (i > 1 && frame_tick) chk("f1_extra_tick", 32'(i), 32'(FRAME));
    end
    @(negedge mclk);
    chk("tick_period48", 32'(frame_tick), 32'h1);

    // Frame 2: new seg_in3 visible; drop en inside slot 3.
    for (int i = 1; i <= 26; i++) begin
      @(negedge mclk);
      if (i == 18) chk("f2_d3_new", 32'(seg_out), 32'h30);
    end
    en = 1'b0;
    @(negedge mclk);
    chk("en_off_dig", 32'(dig_out), 32'h3F);
    chk("en_off_seg", 32'(seg_out), 32'h7F);
    repeat (3) @(negedge mclk);
    chk("en_off_tick", 32'(frame_tick), 32'h0);
    en = 1'b1;
    @(negedge mclk);
    chk("reen_tick", 32'(frame_tick), 32'h1);
    chk("reen_blank0", 32'(dig_out), 32'h3F);
    @(negedge mclk);
    chk("reen_blank1", 32'(dig_out), 32'h3F);
    @(negedge mclk);
    chk("reen_d1_dig", 32'(dig_out), 32'h3E);
    chk("reen_d1_seg", 32'(seg_out), 32'h40);

    // New picture for the next frame, then a mid-frame asynchronous reset.
    seg_in1 = 7'h07; seg_in5 = 7'h7F; dp_mask = 6'b100001;
    wait_tick("tick_after_reen");
    repeat (20) @(negedge mclk);
    #2 rst = 1'b1;
    #1;
    chk("midrst_seg", 32'(seg_out), 32'h7F);
    chk("midrst_dig", 32'(dig_out), 32'h3F);
    chk("midrst_dp", 32'(dp_out), 32'h1);
    chk("midrst_tick", 32'(frame_tick), 32'h0);
    @(negedge mclk);
    rst = 1'b0;
    seg_in2 = 7'h5E;
    wait_tick("tick_after_rst");
    repeat (2 * FRAME) @(negedge mclk);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
